// File: rtl/mem_fetch_ctrl.sv
// mem_fetch_ctrl: issues single-word memory reads and forwards the data to a
// downstream data register. The same register can also be incremented when
// the controller is idle.
//
// Ports
//   CLK       in   1  clock; all state changes on its rising edge
//   CLR       in   1  synchronous active-high reset; aborts any read
//   REQ       in   1  read request; sampled only in IDLE
//   ADDR      in  12  read address; latched together with REQ
//   INC_REQ   in   1  increment request for the downstream register
//   MEM_RD    out  1  memory read strobe (ISSUE and WAIT)
//   MEM_ADDR  out 12  latched read address
//   MEM_DATA  in  16  memory read data; valid when MEM_RDY=1
//   MEM_RDY   in   1  memory data-valid; observed only in WAIT
//   LD        out  1  load strobe to the downstream register (LOAD)
//   INR       out  1  combinational increment strobe
//   inDR      out 16  captured read data
//   BUSY      out  1  controller is not IDLE
//   DONE      out  1  read completed (LOAD)
//   ERR       out  1  read timed out (ERR state)
module mem_fetch_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        REQ,
  input  logic [11:0] ADDR,
  input  logic        INC_REQ,
  output logic        MEM_RD,
  output logic [11:0] MEM_ADDR,
  input  logic [15:0] MEM_DATA,
  input  logic        MEM_RDY,
  output logic        LD,
  output logic        INR,
  output logic [15:0] inDR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  // Last wait-counter value before giving up on the memory.
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic r_mem_rd, w_mem_rd_nxt;
  logic r_ld,     w_ld_nxt;
  logic r_done,   w_done_nxt;
  logic r_err,    w_err_nxt;
  logic r_busy,   w_busy_nxt;

  // State, datapath and registered status flags.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_mem_rd <= 1'b0;
      r_ld     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mem_rd <= w_mem_rd_nxt;
      r_ld     <= w_ld_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state, datapath updates, and status flags decoded from the next
  // state so that the registered flags line up with the state register.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_cnt_nxt    = r_cnt;
    w_mem_rd_nxt = 1'b0;
    w_ld_nxt     = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_busy_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (REQ) begin
          w_addr_nxt  = ADDR;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Data arriving on the last allowed cycle still completes the read.
        if (MEM_RDY) begin
          w_data_nxt  = MEM_DATA;
          w_state_nxt = ST_LOAD;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_LOAD:  w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    w_mem_rd_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
    w_ld_nxt     = (w_state_nxt == ST_LOAD);
    w_done_nxt   = (w_state_nxt == ST_LOAD);
    w_err_nxt    = (w_state_nxt == ST_ERR);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
  end

  assign MEM_RD   = r_mem_rd;
  assign MEM_ADDR = r_addr;
  assign LD       = r_ld;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign BUSY     = r_busy;
  assign inDR     = r_data;

  // A read request in the same cycle wins; the increment is dropped.
  assign INR = INC_REQ && (r_state == ST_IDLE) && !REQ;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed bench for mem_fetch_ctrl (TIMEOUT=4). Inputs change 1 ns after a
// rising edge; outputs are sampled then, away from the edge.
module tb_mem_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        REQ = 1'b0;
  logic [11:0] ADDR = '0;
  logic        INC_REQ = 1'b0;
  logic        MEM_RD;
  logic [11:0] MEM_ADDR;
  logic [15:0] MEM_DATA = '0;
  logic        MEM_RDY = 1'b0;
  logic        LD;
  logic        INR;
  logic [15:0] inDR;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;

  mem_fetch_ctrl #(.TIMEOUT(4)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .REQ      (REQ),
    .ADDR     (ADDR),
    .INC_REQ  (INC_REQ),
    .MEM_RD   (MEM_RD),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DATA (MEM_DATA),
    .MEM_RDY  (MEM_RDY),
    .LD       (LD),
    .INR      (INR),
    .inDR     (inDR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    REQ = 1'b1; ADDR = 12'hFFF; INC_REQ = 1'b0;
    step();
    step();
    CLR = 1'b0; REQ = 1'b0; ADDR = '0;
    #1;
    n_checks++;
    if ({MEM_RD, LD, INR, DONE, ERR, BUSY} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {MEM_RD, LD, INR, DONE, ERR, BUSY});
    end
    n_checks++;
    if (MEM_ADDR !== 12'h000 || inDR !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: MEM_ADDR=%h inDR=%h expected 000/0000", MEM_ADDR, inDR);
    end
    step();
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: BUSY=%b expected 0", BUSY);
    end
  endtask

  // Cycle 0 REQ, cycle 2 ready, LD/DONE in cycle 3 only, idle in cycle 4.
  task automatic test_basic_read();
    REQ = 1'b1; ADDR = 12'h0A5;
    step();
    REQ = 1'b0; ADDR = 12'h000;
    n_checks++;
    if (MEM_RD !== 1'b1 || BUSY !== 1'b1 || LD !== 1'b0 || MEM_ADDR !== 12'h0A5) begin
      n_fail++;
      $display("FAIL basic_issue: MEM_RD=%b BUSY=%b LD=%b MEM_ADDR=%h expected 1 1 0 0a5",
               MEM_RD, BUSY, LD, MEM_ADDR);
    end
    step();
    MEM_RDY = 1'b1; MEM_DATA = 16'hBEEF;
    n_checks++;
    if (MEM_RD !== 1'b1 || LD !== 1'b0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wait: MEM_RD=%b LD=%b DONE=%b expected 1 0 0", MEM_RD, LD, DONE);
    end
    step();
    MEM_RDY = 1'b0; MEM_DATA = 16'h0000;
    n_checks++;
    if (LD !== 1'b1 || DONE !== 1'b1 || inDR !== 16'hBEEF || MEM_RD !== 1'b0 ||
        MEM_ADDR !== 12'h0A5 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load: LD=%b DONE=%b inDR=%h MEM_RD=%b MEM_ADDR=%h BUSY=%b expected 1 1 beef 0 0a5 1",
               LD, DONE, inDR, MEM_RD, MEM_ADDR, BUSY);
    end
    step();
    n_checks++;
    if (LD !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0 || inDR !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL basic_after: LD=%b DONE=%b BUSY=%b inDR=%h expected 0 0 0 beef",
               LD, DONE, BUSY, inDR);
    end
  endtask

  // Four WAIT cycles with no data, then ERR for one cycle, then IDLE.
  task automatic test_timeout();
    int ld_seen;
    ld_seen = 0;
    REQ = 1'b1; ADDR = 12'h3C3;
    step();
    REQ = 1'b0;
    if (LD) ld_seen++;
    step();
    for (int i = 0; i < 4; i++) begin
      if (LD) ld_seen++;
      n_checks++;
      if (MEM_RD !== 1'b1 || ERR !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: MEM_RD=%b ERR=%b expected 1 0", i, MEM_RD, ERR);
      end
      if (i < 3) step();
    end
    step();
    if (LD) ld_seen++;
    n_checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b1 || MEM_RD !== 1'b0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: ERR=%b BUSY=%b MEM_RD=%b DONE=%b expected 1 1 0 0",
               ERR, BUSY, MEM_RD, DONE);
    end
    step();
    if (LD) ld_seen++;
    n_checks++;
    if (ERR !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: ERR=%b BUSY=%b expected 0 0", ERR, BUSY);
    end
    n_checks++;
    if (ld_seen !== 0) begin
      n_fail++;
      $display("FAIL timeout_no_ld: LD pulses=%0d expected 0", ld_seen);
    end
  endtask

  // Data arrives in the 4th (last) WAIT cycle: read completes, no ERR.
  task automatic test_late_ready();
    REQ = 1'b1; ADDR = 12'h456;
    step();
    REQ = 1'b0;
    step();
    step();
    step();
    step();
    MEM_RDY = 1'b1; MEM_DATA = 16'h5A5A;
    n_checks++;
    if (MEM_RD !== 1'b1 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL late_wait4: MEM_RD=%b ERR=%b expected 1 0", MEM_RD, ERR);
    end
    step();
    MEM_RDY = 1'b0; MEM_DATA = 16'h0000;
    n_checks++;
    if (LD !== 1'b1 || ERR !== 1'b0 || inDR !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL late_load: LD=%b ERR=%b inDR=%h expected 1 0 5a5a", LD, ERR, inDR);
    end
    step();
    n_checks++;
    if (ERR !== 1'b0 || BUSY !== 1'b0 || LD !== 1'b0) begin
      n_fail++;
      $display("FAIL late_idle: ERR=%b BUSY=%b LD=%b expected 0 0 0", ERR, BUSY, LD);
    end
  endtask

  // INR in IDLE, dropped against REQ, suppressed while busy.
  task automatic test_inc();
    INC_REQ = 1'b1;
    #1;
    n_checks++;
    if (INR !== 1'b1 || LD !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_idle: INR=%b LD=%b expected 1 0", INR, LD);
    end
    REQ = 1'b1; ADDR = 12'h123;
    #1;
    n_checks++;
    if (INR !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_vs_req: INR=%b expected 0", INR);
    end
    step();
    REQ = 1'b0;
    #1;
    n_checks++;
    if (BUSY !== 1'b1 || MEM_ADDR !== 12'h123 || INR !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_read_started: BUSY=%b MEM_ADDR=%h INR=%b expected 1 123 0",
               BUSY, MEM_ADDR, INR);
    end
    step();
    MEM_RDY = 1'b1; MEM_DATA = 16'h0F0F;
    #1;
    n_checks++;
    if (INR !== 1'b0 || MEM_RD !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_wait: INR=%b MEM_RD=%b expected 0 1", INR, MEM_RD);
    end
    step();
    MEM_RDY = 1'b0;
    #1;
    n_checks++;
    if (LD !== 1'b1 || INR !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_load: LD=%b INR=%b expected 1 0", LD, INR);
    end
    step();
    n_checks++;
    if (INR !== 1'b1 || LD !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_idle_again: INR=%b LD=%b BUSY=%b expected 1 0 0", INR, LD, BUSY);
    end
    INC_REQ = 1'b0;
    #1;
  endtask

  // CLR in WAIT (with data offered) aborts the read and zeroes everything.
  task automatic test_clr_abort();
    REQ = 1'b1; ADDR = 12'h111;
    step();
    REQ = 1'b0;
    step();
    MEM_RDY = 1'b1; MEM_DATA = 16'h1234;
    step();
    MEM_RDY = 1'b0;
    n_checks++;
    if (LD !== 1'b1 || inDR !== 16'h1234) begin
      n_fail++;
      $display("FAIL clr_preload: LD=%b inDR=%h expected 1 1234", LD, inDR);
    end
    step();
    REQ = 1'b1; ADDR = 12'h7FF;
    step();
    REQ = 1'b0;
    step();
    CLR = 1'b1; MEM_RDY = 1'b1; MEM_DATA = 16'hFFFF;
    n_checks++;
    if (MEM_RD !== 1'b1 || MEM_ADDR !== 12'h7FF) begin
      n_fail++;
      $display("FAIL clr_in_wait: MEM_RD=%b MEM_ADDR=%h expected 1 7ff", MEM_RD, MEM_ADDR);
    end
    step();
    CLR = 1'b0; MEM_RDY = 1'b0; MEM_DATA = 16'h0000;
    #1;
    n_checks++;
    if ({MEM_RD, LD, INR, DONE, ERR, BUSY} !== 6'b0 || inDR !== 16'h0000 || MEM_ADDR !== 12'h000) begin
      n_fail++;
      $display("FAIL clr_abort: flags=%b inDR=%h MEM_ADDR=%h expected 000000 0000 000",
               {MEM_RD, LD, INR, DONE, ERR, BUSY}, inDR, MEM_ADDR);
    end
    step();
    n_checks++;
    if (LD !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_ld: LD=%b BUSY=%b expected 0 0", LD, BUSY);
    end
  endtask

  // A second REQ during WAIT is ignored: one LD, original address kept.
  task automatic test_back_to_back();
    int ld_seen;
    ld_seen = 0;
    REQ = 1'b1; ADDR = 12'h321;
    step();
    REQ = 1'b0;
    step();
    REQ = 1'b1; ADDR = 12'hABC;
    step();
    REQ = 1'b0; ADDR = 12'h000;
    MEM_RDY = 1'b1; MEM_DATA = 16'hCAFE;
    n_checks++;
    if (MEM_ADDR !== 12'h321 || MEM_RD !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_wait: MEM_ADDR=%h MEM_RD=%b expected 321 1", MEM_ADDR, MEM_RD);
    end
    step();
    MEM_RDY = 1'b0;
    if (LD) ld_seen++;
    n_checks++;
    if (LD !== 1'b1 || inDR !== 16'hCAFE || MEM_ADDR !== 12'h321) begin
      n_fail++;
      $display("FAIL b2b_load: LD=%b inDR=%h MEM_ADDR=%h expected 1 cafe 321", LD, inDR, MEM_ADDR);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (LD) ld_seen++;
    end
    n_checks++;
    if (ld_seen !== 1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single_ld: LD pulses=%0d BUSY=%b expected 1 0", ld_seen, BUSY);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_read();
    test_timeout();
    test_late_ready();
    test_inc();
    test_clr_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fetch_ctrl.md
MEM_FETCH_CTRL -- requirements
Module: mem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum number of WAIT cycles allowed per read (legal range 1..255).
REQ-002 The block SHALL have port CLK  input  1  the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port CLR  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port REQ  input  1  read request; sampled only in IDLE.
REQ-005 The block SHALL have port ADDR  input  12  read address; sampled together with REQ.
REQ-006 The block SHALL have port INC_REQ  input  1  increment request for the downstream data register.
REQ-007 The block SHALL have port MEM_RD  output  1  memory read strobe.
REQ-008 The block SHALL have port MEM_ADDR  output  12  memory address.
REQ-009 The block SHALL have port MEM_DATA  input  16  memory read data; valid when MEM_RDY=1.
REQ-010 The block SHALL have port MEM_RDY  input  1  memory data-valid.
REQ-011 The block SHALL have port LD  output  1  load strobe to the downstream data register.
REQ-012 The block SHALL have port INR  output  1  increment strobe to the downstream data register.
REQ-013 The block SHALL have port inDR  output  16  load data to the downstream data register.
REQ-014 The block SHALL have ports BUSY, DONE, ERR  output  1 each  status.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, LOAD and ERR.
REQ-016 In IDLE with REQ=1, the FSM SHALL latch ADDR into an internal address register and move to ISSUE.
REQ-017 In IDLE with REQ=0, the FSM SHALL remain in IDLE.
REQ-018 In ISSUE, the FSM SHALL clear the wait counter and move unconditionally to WAIT.
REQ-019 In WAIT with MEM_RDY=1, the FSM SHALL capture MEM_DATA into the data register and move to LOAD.
REQ-020 In WAIT with MEM_RDY=0, the FSM SHALL increment the 8-bit wait counter; when the counter reaches TIMEOUT-1, the FSM SHALL move to ERR.
REQ-021 LOAD and ERR SHALL each last exactly one cycle and then return to IDLE.
REQ-022 MEM_RD SHALL be 1 exactly in ISSUE and WAIT; MEM_ADDR SHALL equal the latched address at all times.
REQ-023 MEM_RDY SHALL be ignored outside WAIT.
REQ-024 LD and DONE SHALL be 1 exactly in LOAD, and inDR SHALL equal the captured data at all times.
REQ-025 ERR SHALL be 1 exactly in the ERR state; LD SHALL stay 0 on a timeout.
REQ-026 BUSY SHALL be 1 in every state other than IDLE.
REQ-027 INR SHALL be combinational: INC_REQ AND state==IDLE AND NOT REQ.
REQ-028 When REQ and INC_REQ are both 1 in IDLE, REQ SHALL win; INC_REQ SHALL be dropped, not queued.
REQ-029 REQ and INC_REQ SHALL be ignored while BUSY=1.
REQ-030 LD and INR SHALL never both be 1 in the same cycle.
REQ-031 The minimum latency SHALL be: REQ in cycle n gives LD=1 in cycle n+3, when MEM_RDY=1 in the first WAIT cycle.
REQ-032 An MEM_RDY arriving in the same cycle the counter reaches TIMEOUT-1 SHALL take priority, so the read completes and does not time out.

Reset
REQ-033 With CLR=1 at a rising CLK edge, the state SHALL become IDLE, and the address register, data register and wait counter SHALL be 0.
REQ-034 Out of reset, MEM_RD, LD, INR, DONE, ERR and BUSY SHALL be 0, inDR SHALL be 16'h0000 and MEM_ADDR SHALL be 12'h000.
REQ-035 CLR SHALL abort any in-progress read with no LD pulse and take priority over all other inputs.
REQ-036 CLR SHALL have no asynchronous effect.

Verification
REQ-037 Directed test: REQ=1, ADDR=12'h0A5 at cycle 0 and MEM_RDY=1 with MEM_DATA=16'hBEEF at cycle 2 -> MEM_ADDR=12'h0A5, LD=DONE=1 with inDR=16'hBEEF in cycle 3 only, BUSY=0 in cycle 4.
REQ-038 Directed test: TIMEOUT=4, REQ with MEM_RDY held 0 -> ERR=1 for one cycle after 4 WAIT cycles, LD never 1, then IDLE.
REQ-039 Directed test: TIMEOUT=4, MEM_RDY=1 in the 4th WAIT cycle -> LD=1 in the next cycle and ERR stays 0.
REQ-040 Directed test: INC_REQ=1 in IDLE -> INR=1 in the same cycle; INC_REQ=1 and REQ=1 together -> INR=0 and the read starts; INC_REQ=1 during WAIT -> INR=0.
REQ-041 Directed test: CLR=1 in the WAIT cycle after MEM_DATA=16'h1234 was latched by an earlier read -> next cycle all outputs 0 and inDR=16'h0000, with no LD.
REQ-042 Directed test: a second REQ pulse during WAIT -> ignored; only one LD is produced.
